accum_sequencer: RTL
====================

# accum_sequencer

Time-multiplexed controller for the neuron accumulation datapath. It accepts one vector of fixed-point products, then drives a single shared `qadd` adder over successive cycles to produce the sum. The result is bit-identical to the fully unrolled combinational accumulator applied to the same elements in index order. It sits between the multiply stage and the activation stage of a layer, trading latency for one adder instead of N_ELEM-1.

## Interface

Parameters:
- `N_ELEM`, default `` `MAX_NEURONS ``: number of vector slots.
- `WIDTH`, default width of `data`: fixed-point word width, in the same sign-magnitude format used by `qadd`.
- `CNT_W`, default `$clog2(N_ELEM+1)`: width of `n_active`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: `vector1` and `n_active` are valid.
- `in_ready`, output, 1: block can accept a vector.
- `vector1`, input, `ARR` (N_ELEM × WIDTH): elements to sum.
- `n_active`, input, CNT_W: number of leading elements to sum; values above N_ELEM are clamped to N_ELEM.
- `out`, output, WIDTH (`data`): accumulated sum.
- `out_valid`, output, 1: `out` holds a completed result.
- `out_ready`, input, 1: consumer accepts the result.
- `busy`, output, 1: high in ACC or DONE.

## Operation

- States:
  - IDLE: `in_ready`=1.
  - ACC: adding.
  - DONE: `out_valid`=1, result held.
- Accept: handshake completes on the edge where `in_valid & in_ready`.
  - On that edge, latch `vector1` into an internal register.
  - Latch n_eff = min(`n_active`, N_ELEM).
  - Set sum <= v[0]; set idx <= 1.
- Next state after accept:
  - n_eff == 0: load sum <= 0 instead of v[0], go to DONE.
  - n_eff == 1: go to DONE.
  - Otherwise: go to ACC.
- ACC, each edge:
  - sum <= qadd(sum, v[idx]); idx <= idx+1.
  - When the element just added is idx == n_eff-1, go to DONE.
- DONE:
  - `out` = sum, held stable while `out_valid`=1 and `out_ready`=0.
  - On `out_valid & out_ready`, go to IDLE.
- Arithmetic:
  - Every addition uses the codebase `qadd` unit, one instance, combinational between the sum register and the selected element.
  - No saturation is added beyond `qadd` behaviour.
  - Summation order is strictly ascending index.
- Input isolation: `vector1` and `n_active` are ignored outside the accept edge. Changes during ACC/DONE must not affect the result.
- Elements at index ≥ n_eff never reach the adder.
- Outputs are registered or decoded purely from state. There is no combinational path from `in_valid`/`out_ready` to any output.

## Timing

- Reset (asynchronous assert, immediate on outputs):
  - state=IDLE, sum=0, idx=0.
  - `out`=0, `out_valid`=0, `busy`=0, `in_ready`=1.
- Reset asserted mid-ACC or in DONE aborts the operation and discards the partial sum. `out_valid` drops without waiting for a clock edge.
- Latency from accept edge to `out_valid` high:
  - max(n_eff,1) clock edges.
  - n_eff=N_ELEM gives N_ELEM cycles.
  - n_eff=1 or 0 gives 1 cycle.
- Throughput: one vector per n_eff+1 cycles with `out_ready` held high.
  - The DONE→IDLE edge does not re-accept.
  - `in_ready` rises the cycle after the output handshake.
- Backpressure: DONE holds indefinitely with `out_ready`=0, and `in_ready` stays 0 meanwhile.
- `in_valid` high during ACC/DONE is not accepted. The requester must hold it until `in_ready`.
- `busy` = ~`in_ready` in every cycle out of reset.

## Test plan

- Reset check: assert `rst` mid-ACC with N_ELEM=4 and `n_active`=4 -> outputs go to reset values immediately; after release `in_ready`=1, and a fresh vector {1,2,3,4} returns `out`=0x0000000A.
- Full-length sum: N_ELEM=4, vector {0x3, 0x5, 0x80000002 (−2), 0x1}, `n_active`=4, `out_ready`=1 -> `out_valid` exactly 4 cycles after accept, `out`=0x00000007. Result also matches the combinational accumulator over the same vector.
- Partial and degenerate lengths with vector {0x3, 0x5, 0x7, 0x9}:
  - `n_active`=2 -> `out`=0x8 after 2 cycles.
  - `n_active`=1 -> `out`=0x3 after 1 cycle.
  - `n_active`=0 -> `out`=0 after 1 cycle.
  - `n_active`=7 -> clamped to 4, `out`=0x18 after 4 cycles.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` -> `out` stable, `in_ready`=0. Meanwhile `vector1` is changed and `in_valid`=1, with no effect. On `out_ready`=1 the result is consumed, and `in_ready`=1 the following cycle.
- Back-to-back: two vectors {1,1,1,1} then {2,2,2,2}, `in_valid` and `out_ready` held high -> results 0x4 then 0x8, with accept edges 5 cycles apart. No accept occurs on the DONE→IDLE edge.

Source files
------------

// File: rtl/accum_sequencer.sv
// Time-multiplexed neuron accumulator: latches one product vector and sums its
// leading n_eff elements through a single shared sign-magnitude qadd adder.

`ifndef MAX_NEURONS
`define MAX_NEURONS 4
`endif

module qadd #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);
  logic             w_sa, w_sb, w_sign;
  logic [WIDTH-2:0] w_ma, w_mb, w_mag;

  assign w_sa = i_a[WIDTH-1];
  assign w_sb = i_b[WIDTH-1];
  assign w_ma = i_a[WIDTH-2:0];
  assign w_mb = i_b[WIDTH-2:0];

  // Like signs add magnitudes (carry out is dropped); unlike signs subtract the
  // smaller magnitude from the larger and keep the larger operand's sign.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_sign = w_sa;
    w_mag  = '0;
    if (w_sa == w_sb) begin
      w_mag = w_ma + w_mb;
    end else if (w_ma >= w_mb) begin
      w_mag = w_ma - w_mb;
    end else begin
      w_mag  = w_mb - w_ma;
      w_sign = w_sb;
    end
    if (w_mag == '0) w_sign = 1'b0;
  end

  assign o_sum = {w_sign, w_mag};
endmodule

module accum_sequencer #(
  parameter int N_ELEM = `MAX_NEURONS,
  parameter int WIDTH  = 32,
  parameter int CNT_W  = $clog2(N_ELEM + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_ELEM-1:0][WIDTH-1:0] vector1,
  input  logic [CNT_W-1:0]             n_active,
  output logic [WIDTH-1:0]             out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);
  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t                      r_state, w_next;
  logic [N_ELEM-1:0][WIDTH-1:0] r_vec;
  logic [WIDTH-1:0]            r_sum;
  logic [CNT_W-1:0]            r_idx, r_n_eff;
  logic [CNT_W-1:0]            w_n_eff;
  logic [WIDTH-1:0]            w_qsum;
  logic [IDX_W-1:0]            w_sel;
  logic                        w_accept;

  assign w_n_eff  = (n_active > CNT_W'(N_ELEM)) ? CNT_W'(N_ELEM) : n_active;
  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_sel    = r_idx[IDX_W-1:0];

  qadd #(.WIDTH(WIDTH)) u_qadd (
    .i_a   (r_sum),
    .i_b   (r_vec[w_sel]),
    .o_sum (w_qsum)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = (w_n_eff <= CNT_W'(1)) ? S_DONE : S_ACC;
      S_ACC:  if (r_idx == r_n_eff - CNT_W'(1)) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  // NOTE: the element store has no reset; it is only read after an accept has loaded it.
  always_ff @(posedge clk) begin
    if (w_accept) r_vec <= vector1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_idx   <= '0;
      r_n_eff <= '0;
    end else if (w_accept) begin
      r_n_eff <= w_n_eff;
      r_idx   <= CNT_W'(1);
      r_sum   <= (w_n_eff == '0) ? '0 : vector1[0];
    end else if (r_state == S_ACC) begin
      r_sum <= w_qsum;
      r_idx <= r_idx + CNT_W'(1);
    end
  end

  assign out = r_sum;
endmodule
